// File: rtl/interval_timer_ctrl.sv
// Interval timer: prescaled countdown with IDLE/RUN/PAUSED/EXPIRED control FSM.
// Define TIMER_AUTORELOAD_EN to reload the countdown on expiry instead of stopping.
module interval_timer_ctrl #(
  parameter int unsigned TICK_DIV = 40000000
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       start,
  input  logic       pause,
  input  logic       stop,
  input  logic       ack,
  output logic [7:0] remaining,
  output logic       tick_out,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PAUSED  = 2'd2,
    S_EXPIRED = 2'd3
  } state_t;

  localparam logic [25:0] PRESC_MAX = 26'(TICK_DIV - 1);

  state_t      r_state;
  logic [25:0] r_presc;
  logic [7:0]  r_remaining;
  logic        r_tick;
  logic        r_busy;
  logic        r_done;
  logic        w_tick;
`ifdef TIMER_AUTORELOAD_EN
  logic [7:0]  r_reload;
`endif

  assign w_tick    = (r_presc == PRESC_MAX);
  assign remaining = r_remaining;
  assign tick_out  = r_tick;
  assign busy      = r_busy;
  assign done      = r_done;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_presc     <= '0;
      r_remaining <= '0;
      r_tick      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef TIMER_AUTORELOAD_EN
      r_reload    <= '0;
`endif
    end else begin
      r_tick <= 1'b0;
`ifdef TIMER_AUTORELOAD_EN
      r_done <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (load) begin
            r_remaining <= load_val;
`ifdef TIMER_AUTORELOAD_EN
            r_reload    <= load_val;
`endif
          end else if (start && (r_remaining != 8'd0)) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_presc <= '0;
          end
        end

        S_RUN: begin
          if (stop) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_presc <= '0;
          end else begin
            r_presc <= w_tick ? '0 : r_presc + 26'd1;
            r_tick  <= w_tick;
            if (w_tick && (r_remaining == 8'd1)) begin
`ifdef TIMER_AUTORELOAD_EN
              r_remaining <= r_reload;
              r_done      <= 1'b1;
              if (pause) begin
                r_state <= S_PAUSED;
              end
`else
              // Expiry wins over a coincident pause.
              r_remaining <= 8'd0;
              r_done      <= 1'b1;
              r_state     <= S_EXPIRED;
              r_busy      <= 1'b0;
`endif
            end else begin
              if (w_tick && (r_remaining != 8'd0)) begin
                r_remaining <= r_remaining - 8'd1;
              end
              if (pause) begin
                r_state <= S_PAUSED;
              end
            end
          end
        end

        S_PAUSED: begin
          if (stop) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_presc <= '0;
          end else if (!pause && start) begin
            r_state <= S_RUN;
          end
        end

        S_EXPIRED: begin
          if (ack) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Scoreboard bench for interval_timer_ctrl (TICK_DIV=4): directed scenarios then random control traffic.
// The reference model follows TIMER_AUTORELOAD_EN the same way the design does.
module tb_interval_timer_ctrl;

  localparam int TICK_DIV = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXPIRED = 3;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'd0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       stop = 1'b0;
  logic       ack = 1'b0;
  logic [7:0] remaining;
  logic       tick_out;
  logic       busy;
  logic       done;

  typedef struct {
    logic [7:0] rem;
    logic       tick;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  // Reference model state: spec-level mode, countdown, and cycles since last tick.
  int         m_mode = M_IDLE;
  int         m_phase = 0;
  logic [7:0] m_rem = 8'd0;
  logic [7:0] m_reload = 8'd0;
  logic       m_tick = 1'b0;
  logic       m_busy = 1'b0;
  logic       m_done = 1'b0;

  interval_timer_ctrl #(.TICK_DIV(TICK_DIV)) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .pause    (pause),
    .stop     (stop),
    .ack      (ack),
    .remaining(remaining),
    .tick_out (tick_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, cyc, got, want);
    end
  endtask

  task automatic model_step(input bit r, input bit ld, input logic [7:0] lv,
                            input bit st, input bit pa, input bit sp, input bit ak);
    m_tick = 1'b0;
`ifdef TIMER_AUTORELOAD_EN
    m_done = 1'b0;
`endif
    if (r) begin
      m_mode = M_IDLE; m_phase = 0; m_rem = 8'd0; m_reload = 8'd0; m_done = 1'b0;
    end else if (m_mode == M_IDLE) begin
      if (ld) begin
        m_rem = lv; m_reload = lv;
      end else if (st && m_rem != 8'd0) begin
        m_mode = M_RUN; m_phase = 0;
      end
    end else if (m_mode == M_RUN) begin
      if (sp) begin
        m_mode = M_IDLE; m_phase = 0;
      end else begin
        m_phase = (m_phase + 1) % TICK_DIV;
        m_tick = (m_phase == 0);
        if (pa) m_mode = M_PAUSED;
        if (m_tick) begin
          if (m_rem > 8'd1) m_rem = m_rem - 8'd1;
          else begin
`ifdef TIMER_AUTORELOAD_EN
            m_rem = m_reload; m_done = 1'b1;
`else
            m_rem = 8'd0; m_done = 1'b1; m_mode = M_EXPIRED;
`endif
          end
        end
      end
    end else if (m_mode == M_PAUSED) begin
      if (sp) begin
        m_mode = M_IDLE; m_phase = 0;
      end else if (!pa && st) begin
        m_mode = M_RUN;
      end
    end else begin
      if (ak) begin
        m_mode = M_IDLE; m_done = 1'b0;
      end
    end
    m_busy = (m_mode == M_RUN) || (m_mode == M_PAUSED);
  endtask

  task automatic drive(input bit r, input bit ld, input logic [7:0] lv,
                       input bit st, input bit pa, input bit sp, input bit ak);
    exp_t e;
    @(negedge clk_in);
    rst = r; load = ld; load_val = lv; start = st; pause = pa; stop = sp; ack = ak;
    model_step(r, ld, lv, st, pa, sp, ak);
    e.rem = m_rem; e.tick = m_tick; e.busy = m_busy; e.done = m_done;
    sb_q.push_back(e);
  endtask

  task automatic idle_n(input int n);
    for (int k = 0; k < n; k++) drive(0, 0, 8'd0, 0, 0, 0, 0);
  endtask

  // Monitor: one expected record per clock edge once stimulus is flowing.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_in);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        cyc++;
        chk("remaining", remaining, e.rem);
        chk("tick_out", {7'd0, tick_out}, {7'd0, e.tick});
        chk("busy", {7'd0, busy}, {7'd0, e.busy});
        chk("done", {7'd0, done}, {7'd0, e.done});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cycle=%0d got=running want=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    bit         r_b, ld_b, st_b, pa_b, sp_b, ak_b;
    logic [7:0] lv_b;

    $display("scenario: countdown 3 to expiry and ack");
    drive(1, 0, 8'd0, 0, 0, 0, 0);
    drive(0, 1, 8'd3, 0, 0, 0, 0);
    drive(0, 0, 8'd0, 1, 0, 0, 0);
    idle_n(16);
    drive(0, 0, 8'd0, 1, 1, 1, 0);
    drive(0, 0, 8'd0, 0, 0, 0, 1);
    idle_n(2);

    $display("scenario: pause mid-phase and resume");
    drive(0, 1, 8'd5, 0, 0, 0, 0);
    drive(0, 0, 8'd0, 1, 0, 0, 0);
    idle_n(10);
    drive(0, 0, 8'd0, 0, 1, 0, 0);
    idle_n(10);
    drive(0, 0, 8'd0, 1, 0, 0, 0);
    idle_n(8);
    drive(0, 0, 8'd0, 0, 0, 1, 0);

    $display("scenario: start with zero, load beats start");
    drive(1, 0, 8'd0, 0, 0, 0, 0);
    drive(0, 0, 8'd0, 1, 0, 0, 0);
    drive(0, 1, 8'd2, 1, 0, 0, 0);
    idle_n(3);
    drive(0, 0, 8'd0, 0, 0, 0, 1);

    $display("scenario: stop with pause at 4, reset during run");
    drive(0, 1, 8'd6, 0, 0, 0, 0);
    drive(0, 0, 8'd0, 1, 0, 0, 0);
    idle_n(9);
    drive(0, 0, 8'd0, 0, 1, 1, 0);
    drive(0, 0, 8'd0, 1, 0, 0, 0);
    idle_n(5);
    drive(1, 0, 8'd0, 1, 0, 0, 0);
    idle_n(2);

    $display("scenario: pause coincident with final tick");
    drive(0, 1, 8'd1, 0, 0, 0, 0);
    drive(0, 0, 8'd0, 1, 0, 0, 0);
    idle_n(3);
    drive(0, 0, 8'd0, 0, 1, 0, 0);
    idle_n(2);
    drive(0, 0, 8'd0, 0, 0, 0, 1);

    $display("scenario: autoreload-length run of 2");
    drive(0, 1, 8'd2, 0, 0, 0, 0);
    drive(0, 0, 8'd0, 1, 0, 0, 0);
    idle_n(20);
    drive(0, 0, 8'd0, 0, 0, 0, 1);
    drive(0, 0, 8'd0, 0, 0, 1, 0);
    drive(0, 0, 8'd0, 0, 0, 0, 1);

    $display("scenario: random traffic");
    for (int i = 0; i < 3000; i++) begin
      r_b  = ($urandom_range(0, 199) < 2);
      ld_b = ($urandom_range(0, 99) < 8);
      lv_b = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'($urandom_range(0, 4));
      st_b = ($urandom_range(0, 99) < 25);
      pa_b = ($urandom_range(0, 99) < 8);
      sp_b = ($urandom_range(0, 99) < 3);
      ak_b = ($urandom_range(0, 99) < 15);
      drive(r_b, ld_b, lv_b, st_b, pa_b, sp_b, ak_b);
    end

    @(posedge clk_in);
    #2;
    chk("scoreboard_drain", 8'(sb_q.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/interval_timer_ctrl.md
INTERVAL_TIMER_CTRL -- requirements
Module: interval_timer_ctrl

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 40000000, giving clk_in cycles per tick (1 Hz at 40 MHz); legal range 2..2^26.
REQ-002 The block SHALL have port clk_in, input, 1, system clock (40 MHz); all logic on its rising edge.
REQ-003 The block SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 The block SHALL have port load, input, 1, request to latch load_val as the countdown value.
REQ-005 The block SHALL have port load_val, input, 8, countdown length in ticks.
REQ-006 The block SHALL have port start, input, 1, start from IDLE or resume from PAUSED.
REQ-007 The block SHALL have port pause, input, 1, freeze a running countdown.
REQ-008 The block SHALL have port stop, input, 1, abort to IDLE.
REQ-009 The block SHALL have port ack, input, 1, acknowledge of done.
REQ-010 The block SHALL have port remaining, output, 8, current countdown value (registered).
REQ-011 The block SHALL have port tick_out, output, 1, one-cycle pulse per elapsed tick while running.
REQ-012 The block SHALL have port busy, output, 1, high in RUN or PAUSED.
REQ-013 The block SHALL have port done, output, 1, expiry flag held until acknowledged.

Function
REQ-014 The FSM SHALL have states IDLE, RUN, PAUSED, EXPIRED; all outputs registered.
REQ-015 The 26-bit prescaler SHALL count 0..TICK_DIV-1 only in RUN, wrap to 0, and assert tick_out for the cycle after reaching TICK_DIV-1.
REQ-016 The prescaler SHALL be cleared on entry to RUN from IDLE and held (not cleared) in PAUSED.
REQ-017 In IDLE, load=1 SHALL copy load_val into remaining and the reload register next cycle; load SHALL be ignored in all other states.
REQ-018 In IDLE, start=1 with remaining!=0 SHALL enter RUN next cycle; start with remaining==0 SHALL be ignored; load and start together SHALL give load priority (no start that cycle).
REQ-019 In RUN, each tick SHALL decrement remaining by 1; the tick taking remaining 1->0 SHALL move to EXPIRED and set done the same cycle remaining becomes 0.
REQ-020 remaining SHALL never wrap below 0.
REQ-021 Control priority in RUN/PAUSED SHALL be stop > pause > start; stop SHALL go to IDLE next cycle, retaining remaining, clearing the prescaler.
REQ-022 In RUN, pause=1 SHALL enter PAUSED; a tick coinciding with pause SHALL still decrement (or expire, which overrides pause).
REQ-023 In PAUSED, start=1 SHALL return to RUN with prescaler continuing from its held value.
REQ-024 In EXPIRED, done SHALL stay high until ack=1, then clear and enter IDLE next cycle; start/pause/stop/load SHALL be ignored in EXPIRED.
REQ-025 ack outside EXPIRED SHALL have no effect.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE, prescaler=0, remaining=0, reload=0, tick_out=0, busy=0, done=0, from any state including mid-countdown; rst overrides all inputs.

Configuration
REQ-027 Macro TIMER_AUTORELOAD_EN defined: the 1->0 tick SHALL reload remaining from the reload register, stay in RUN, pulse done one cycle, never enter EXPIRED, ignore ack.
REQ-028 Macro TIMER_AUTORELOAD_EN undefined: behaviour SHALL be exactly REQ-019 and REQ-024 (one-shot).

Verification (TICK_DIV=4)
REQ-029 rst; load_val=3 load; start -> busy=1, tick_out every 4 cycles, remaining 3,2,1,0, done=1 with remaining=0, held until ack, then IDLE, busy=0.
REQ-030 remaining=5, run 2 ticks, pause 10 cycles, start -> remaining holds 3 through pause, next tick resumes from held prescaler phase.
REQ-031 start with remaining=0 -> stays IDLE, busy=0; load+start same cycle with load_val=2 -> remaining=2, IDLE.
REQ-032 stop and pause together in RUN at remaining=4 -> IDLE, remaining=4, prescaler 0; rst during RUN -> all outputs 0 next cycle.
REQ-033 pause coincident with tick at remaining=1 -> EXPIRED, done=1 (not PAUSED).
REQ-034 TIMER_AUTORELOAD_EN defined, load_val=2 -> remaining 2,1,2,1..., done one-cycle pulse each wrap, busy stays 1.
